// File: rtl/bsg_mem_1r1w_sync_banked_fwd.sv
//------------------------------------------------------------------------------
// bsg_mem_1r1w_sync_banked_fwd
//   Banked synchronous 1R1W RAM with per-bit write mask, same-address
//   write->read forwarding, read-valid strobe and read-data hold.
//   Optional parity storage/check: define BSG_MEM_1R1W_SYNC_PARITY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_mem_1r1w_sync_banked_fwd #(
  parameter int width_p                = 64,
  parameter int els_p                  = 512,
  parameter int banks_p                = 2,
  parameter int read_write_same_addr_p = 1,
  localparam int addr_width_lp         = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o,
  output logic                     r_v_o,
  output logic                     r_parity_err_o
);

  localparam int lg_banks_lp = (banks_p > 1) ? $clog2(banks_p) : 0;
  localparam int bank_w_lp   = (banks_p > 1) ? lg_banks_lp : 1;
  localparam int rows_lp     = els_p / banks_p;
  localparam int row_w_lp    = (rows_lp > 1) ? $clog2(rows_lp) : 1;
`ifdef BSG_MEM_1R1W_SYNC_PARITY_EN
  localparam int store_w_lp  = width_p + 1;
`else
  localparam int store_w_lp  = width_p;
`endif
  localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);
  localparam logic [addr_width_lp-1:0] bank_mask_lp = addr_width_lp'(banks_p - 1);

  logic [bank_w_lp-1:0]  w_w_bank, w_r_bank;
  logic [row_w_lp-1:0]   w_w_row, w_r_row;
  logic                  w_w_ok, w_r_ok;
  logic                  w_wen, w_ren, w_same;
  logic [store_w_lp-1:0] w_bank_rdata [banks_p];
  logic [store_w_lp-1:0] w_out;

  logic [bank_w_lp-1:0]  r_rd_bank;
  logic                  r_v_q;

  assign w_w_bank = bank_w_lp'(w_addr_i & bank_mask_lp);
  assign w_r_bank = bank_w_lp'(r_addr_i & bank_mask_lp);
  assign w_w_row  = row_w_lp'(w_addr_i >> lg_banks_lp);
  assign w_r_row  = row_w_lp'(r_addr_i >> lg_banks_lp);
  assign w_w_ok   = {1'b0, w_addr_i} < els_lp;
  assign w_r_ok   = {1'b0, r_addr_i} < els_lp;

  // Requests are dropped outright while reset is held.
  assign w_wen  = w_v_i & ~reset_i & w_w_ok;
  assign w_ren  = r_v_i & ~reset_i;
  assign w_same = w_v_i & r_v_i & (w_addr_i == r_addr_i);

  for (genvar b = 0; b < banks_p; b++) begin : g_bank
    logic [store_w_lp-1:0] r_mem [rows_lp];
    logic [store_w_lp-1:0] r_rdata;
    logic [store_w_lp-1:0] w_fwd_word;
    logic [width_p-1:0]    w_rd_merge;
    logic                  w_bank_we, w_bank_re, w_bank_fwd;

    assign w_bank_we  = w_wen & (w_w_bank == bank_w_lp'(b));
    assign w_bank_re  = w_ren & (w_r_bank == bank_w_lp'(b));
    assign w_bank_fwd = w_bank_we & w_bank_re & (w_w_row == w_r_row);
    // Collision implies identical rows, so this is the merged post-write word.
    assign w_rd_merge = (r_mem[w_r_row][width_p-1:0] & ~w_mask_i) | (w_data_i & w_mask_i);

`ifdef BSG_MEM_1R1W_SYNC_PARITY_EN
    logic [width_p-1:0] w_wr_merge;
    assign w_wr_merge = (r_mem[w_w_row][width_p-1:0] & ~w_mask_i) | (w_data_i & w_mask_i);
    assign w_fwd_word = {^w_rd_merge, w_rd_merge};

    always_ff @(posedge clk_i) begin
      if (w_bank_we) r_mem[w_w_row] <= {^w_wr_merge, w_wr_merge};
    end
`else
    assign w_fwd_word = w_rd_merge;

    always_ff @(posedge clk_i) begin
      if (w_bank_we) begin
        for (int i = 0; i < width_p; i++) begin
          if (w_mask_i[i]) r_mem[w_w_row][i] <= w_data_i[i];
        end
      end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_rdata <= '0;
      end else if (w_bank_re) begin
        if (!w_r_ok)
          r_rdata <= 'x;
        else if (w_bank_fwd)
          r_rdata <= (read_write_same_addr_p != 0) ? w_fwd_word : 'x;
        else
          r_rdata <= r_mem[w_r_row];
      end
    end

    assign w_bank_rdata[b] = r_rdata;
  end

  // The bank register only updates on its own reads, so steering by the last
  // read bank gives the hold behaviour for free.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v_q     <= 1'b0;
      r_rd_bank <= '0;
    end else begin
      r_v_q <= w_ren;
      if (w_ren) r_rd_bank <= w_r_bank;
    end
  end

  assign w_out    = w_bank_rdata[r_rd_bank];
  assign r_data_o = w_out[width_p-1:0];
  assign r_v_o    = r_v_q;

`ifdef BSG_MEM_1R1W_SYNC_PARITY_EN
  assign r_parity_err_o = r_v_q & (^w_out);
`else
  assign r_parity_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (w_v_i) assert (w_w_ok) else $error("write address %0d out of range", w_addr_i);
      if (r_v_i) assert (w_r_ok) else $error("read address %0d out of range", r_addr_i);
      if (read_write_same_addr_p == 0)
        assert (!w_same) else $error("illegal same-address read/write at %0d", r_addr_i);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_mem_1r1w_sync_banked_fwd.sv
//------------------------------------------------------------------------------
// tb_bsg_mem_1r1w_sync_banked_fwd
//   Directed self-checking bench for the banked forwarding 1R1W RAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_mem_1r1w_sync_banked_fwd;

  localparam int width_p = 64;
  localparam int els_p   = 512;
  localparam int aw_lp   = $clog2(els_p);

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               w_v_i;
  logic [aw_lp-1:0]   w_addr_i;
  logic [width_p-1:0] w_data_i;
  logic [width_p-1:0] w_mask_i;
  logic               r_v_i;
  logic [aw_lp-1:0]   r_addr_i;
  logic [width_p-1:0] r_data_o;
  logic               r_v_o;
  logic               r_parity_err_o;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [width_p-1:0] full_lp = {width_p{1'b1}};

  bsg_mem_1r1w_sync_banked_fwd #(
    .width_p(width_p), .els_p(els_p), .banks_p(2), .read_write_same_addr_p(1)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
    .r_v_i(r_v_i), .r_addr_i(r_addr_i),
    .r_data_o(r_data_o), .r_v_o(r_v_o), .r_parity_err_o(r_parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [width_p-1:0] obs, input logic [width_p-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input int addr, input logic [width_p-1:0] data, input logic [width_p-1:0] mask);
    w_v_i = 1'b1; w_addr_i = aw_lp'(addr); w_data_i = data; w_mask_i = mask;
  endtask

  task automatic rd(input int addr);
    r_v_i = 1'b1; r_addr_i = aw_lp'(addr);
  endtask

  task automatic idle();
    w_v_i = 1'b0; r_v_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    w_addr_i = '0; w_data_i = '0; w_mask_i = '0; r_addr_i = '0;
    step(); step();
    chk("reset_r_v", {63'b0, r_v_o}, 64'd0);
    chk("reset_data", r_data_o, 64'd0);
    chk("reset_perr", {63'b0, r_parity_err_o}, 64'd0);
    reset_i = 1'b0;

    // Full-mask write then read.
    wr(3, 64'hA5A5_A5A5_A5A5_A5A5, full_lp); step();
    idle(); rd(3); step();
    idle();
    chk("rd3_v", {63'b0, r_v_o}, 64'd1);
    chk("rd3_data", r_data_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("rd3_perr", {63'b0, r_parity_err_o}, 64'd0);
    step();
    chk("rd3_v_drop", {63'b0, r_v_o}, 64'd0);
    chk("rd3_hold", r_data_o, 64'hA5A5_A5A5_A5A5_A5A5);

    // Masked write clearing only the low byte, then a zero-mask no-op write.
    wr(8, full_lp, full_lp); step();
    wr(8, 64'd0, 64'h0000_0000_0000_00FF); step();
    wr(8, 64'd0, 64'd0); step();
    idle(); rd(8); step();
    idle();
    chk("mask_data", r_data_o, 64'hFFFF_FFFF_FFFF_FF00);

    // Same-cycle write+read forwards the merged word.
    wr(5, 64'd0, full_lp); step();
    wr(5, 64'h1234, full_lp); rd(5); step();
    idle();
    chk("fwd_full_v", {63'b0, r_v_o}, 64'd1);
    chk("fwd_full", r_data_o, 64'h1234);
    wr(5, 64'hABCD, 64'hFF00); rd(5); step();
    idle();
    chk("fwd_masked", r_data_o, 64'hAB34);

    // Write/read in different banks same cycle, then back-to-back reads.
    wr(2, 64'h77, full_lp); step();
    wr(7, 64'h99, full_lp); rd(2); step();
    chk("xbank_rd2", r_data_o, 64'h77);
    idle(); rd(7); step();
    chk("b2b_rd7_v", {63'b0, r_v_o}, 64'd1);
    chk("b2b_rd7", r_data_o, 64'h99);
    rd(2); step();
    idle();
    chk("b2b_rd2", r_data_o, 64'h77);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_data_%0d", i), r_data_o, 64'h77);
      chk($sformatf("hold_v_%0d", i), {63'b0, r_v_o}, 64'd0);
    end

    // Write followed immediately by a read of the same address.
    wr(9, 64'h5555, full_lp); step();
    idle(); rd(9); step();
    idle();
    chk("wr_then_rd", r_data_o, 64'h5555);

    // Reset arrives while a read is in flight.
    rd(2); step();
    idle(); rd(3);
    #2 reset_i = 1'b1;
    #1;
    chk("rst_mid_v", {63'b0, r_v_o}, 64'd0);
    chk("rst_mid_data", r_data_o, 64'd0);
    step();
    chk("rst_hold_v", {63'b0, r_v_o}, 64'd0);
    chk("rst_hold_data", r_data_o, 64'd0);
    idle();
    reset_i = 1'b0;
    step();
    chk("post_rst_idle_v", {63'b0, r_v_o}, 64'd0);
    rd(3); step();
    idle();
    chk("post_rst_v", {63'b0, r_v_o}, 64'd1);
    chk("post_rst_data", r_data_o, 64'hA5A5_A5A5_A5A5_A5A5);

`ifdef BSG_MEM_1R1W_SYNC_PARITY_EN
    wr(1, 64'h0F0F, full_lp); step();
    idle();
    dut.g_bank[1].r_mem[0][0] = ~dut.g_bank[1].r_mem[0][0];
    rd(1); step();
    idle();
    chk("perr_v", {63'b0, r_v_o}, 64'd1);
    chk("perr_flag", {63'b0, r_parity_err_o}, 64'd1);
    rd(3); step();
    idle();
    chk("perr_clean", {63'b0, r_parity_err_o}, 64'd0);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
